// File: rtl/ysyx_25020037_ifu.sv
// ysyx_25020037_ifu: instruction fetch unit; issues one bus read per PC and hands the packet to decode.
//   clk, rst_n                    : clock, async active-low reset
//   pc_update_valid, dnpc         : next-PC strobe and address from writeback
//   arvalid, araddr, arready      : read-address channel
//   rvalid, rdata, rresp, rready  : read-data channel
//   ifu_rvalid, pc, inst, ifu_fault, idu_ready : fetch packet to decode
module ysyx_25020037_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_update_valid,
  input  logic [31:0] dnpc,
  output logic        arvalid,
  output logic [31:0] araddr,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        rready,
  output logic        ifu_rvalid,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        ifu_fault,
  input  logic        idu_ready
);
  typedef enum logic [1:0] {S_AR, S_R, S_HOLD, S_WAIT} state_t;
  state_t state, state_n;
  logic        pend;
  logic [31:0] pend_addr;
  logic [31:0] upd_addr;
  logic        go;
  assign araddr = pc;
  // A fresh strobe in S_WAIT wins over an older pending address.
  assign upd_addr = pc_update_valid ? dnpc : pend_addr;
  assign go = pend | pc_update_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_AR;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_AR:    state_n = (!arvalid && pc[1:0] != 2'b00) ? S_HOLD : (arvalid && arready) ? S_R : S_AR;
      S_R:     state_n = (rvalid && rready) ? S_HOLD : S_R;
      S_HOLD:  state_n = idu_ready ? S_WAIT : S_HOLD;
      default: state_n = go ? S_AR : S_WAIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      ifu_rvalid <= 1'b0;
      ifu_fault  <= 1'b0;
      inst       <= 32'h0;
      pend       <= 1'b0;
      pend_addr  <= 32'h0;
    end else begin
      case (state)
        S_AR:
          if (!arvalid) begin
            // arvalid is low here only right after reset or for a misaligned PC.
            if (pc[1:0] != 2'b00) begin
              inst       <= 32'h0;
              ifu_fault  <= 1'b1;
              ifu_rvalid <= 1'b1;
            end else arvalid <= 1'b1;
          end else if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        S_R:
          if (rvalid && rready) begin
            inst       <= rdata;
            ifu_fault  <= rresp != 2'b00;
            rready     <= 1'b0;
            ifu_rvalid <= 1'b1;
          end
        S_HOLD:
          if (idu_ready) begin
            ifu_rvalid <= 1'b0;
            ifu_fault  <= 1'b0;
          end
        default:
          if (go) begin
            pc      <= upd_addr;
            // Raise arvalid at the same edge so a zero-wait fetch takes three cycles.
            arvalid <= upd_addr[1:0] == 2'b00;
          end
      endcase
      if (state == S_WAIT) pend <= 1'b0;
      else if (pc_update_valid) begin
        pend      <= 1'b1;
        pend_addr <= dnpc;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// tb_ysyx_25020037_ifu: directed self-checking bench for the fetch unit.
module tb_ysyx_25020037_ifu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_update_valid;
  logic [31:0] dnpc;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;
  logic        ifu_rvalid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        ifu_fault;
  logic        idu_ready;
  int vectors = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ysyx_25020037_ifu dut (
    .clk(clk), .rst_n(rst_n), .pc_update_valid(pc_update_valid), .dnpc(dnpc),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .ifu_rvalid(ifu_rvalid), .pc(pc), .inst(inst), .ifu_fault(ifu_fault),
    .idu_ready(idu_ready)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0; pc_update_valid = 1'b0; dnpc = 32'h0; arready = 1'b0;
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; idu_ready = 1'b0;
    tick; tick;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_ifu_rvalid", ifu_rvalid, 0);
    chk("rst_fault", ifu_fault, 0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_araddr", araddr, 32'h3000_0000);
    rst_n = 1'b1;
    tick;
    chk("first_arvalid", arvalid, 1);
    chk("first_araddr", araddr, 32'h3000_0000);
    arready = 1'b1;
    tick;
    chk("ar_hs_arvalid", arvalid, 0);
    chk("ar_hs_rready", rready, 1);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0010_0093;
    tick;
    rvalid = 1'b0; rdata = 32'h1234_5678;
    chk("pkt_valid", ifu_rvalid, 1);
    chk("pkt_inst", inst, 32'h0010_0093);
    chk("pkt_pc", pc, 32'h3000_0000);
    chk("pkt_fault", ifu_fault, 0);
    chk("pkt_rready", rready, 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("hold_valid", ifu_rvalid, 1);
      chk("hold_inst", inst, 32'h0010_0093);
      chk("hold_arvalid", arvalid, 0);
    end
    idu_ready = 1'b1;
    tick;
    idu_ready = 1'b0;
    chk("hs_drop", ifu_rvalid, 0);
    rvalid = 1'b1; rdata = 32'hFFFF_FFFF; arready = 1'b1;
    tick; tick;
    rvalid = 1'b0; arready = 1'b0;
    chk("wait_arvalid", arvalid, 0);
    chk("wait_ignore_rdata", inst, 32'h0010_0093);
    chk("wait_ifu_rvalid", ifu_rvalid, 0);
    pc_update_valid = 1'b1; dnpc = 32'h3000_0004;
    tick;
    pc_update_valid = 1'b0;
    chk("upd_arvalid", arvalid, 1);
    chk("upd_araddr", araddr, 32'h3000_0004);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("ar_wait_arvalid", arvalid, 1);
      chk("ar_wait_araddr", araddr, 32'h3000_0004);
    end
    arready = 1'b1;
    tick;
    arready = 1'b0;
    chk("slow_ar_hs", arvalid, 0);
    chk("slow_rready", rready, 1);
    pc_update_valid = 1'b1; dnpc = 32'h3000_0010;
    tick;
    pc_update_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("r_wait_rready", rready, 1);
      chk("r_wait_valid", ifu_rvalid, 0);
      chk("r_wait_arvalid", arvalid, 0);
      tick;
    end
    rvalid = 1'b1; rdata = 32'h0000_0013;
    tick;
    rvalid = 1'b0;
    chk("slow_pkt_valid", ifu_rvalid, 1);
    chk("slow_pkt_inst", inst, 32'h0000_0013);
    chk("slow_pkt_pc", pc, 32'h3000_0004);
    chk("slow_single_ar", arvalid, 0);
    idu_ready = 1'b1;
    tick;
    idu_ready = 1'b0;
    chk("pend_drop", ifu_rvalid, 0);
    tick;
    chk("pend_arvalid", arvalid, 1);
    chk("pend_araddr", araddr, 32'h3000_0010);
    arready = 1'b1;
    tick;
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    tick;
    rvalid = 1'b0; rresp = 2'b00;
    chk("err_inst", inst, 32'hDEAD_BEEF);
    chk("err_fault", ifu_fault, 1);
    chk("err_valid", ifu_rvalid, 1);
    idu_ready = 1'b1;
    tick;
    idu_ready = 1'b0;
    chk("err_clr_valid", ifu_rvalid, 0);
    chk("err_clr_fault", ifu_fault, 0);
    pc_update_valid = 1'b1; dnpc = 32'h3000_0002;
    tick;
    pc_update_valid = 1'b0;
    chk("mis_no_ar", arvalid, 0);
    tick;
    chk("mis_no_ar2", arvalid, 0);
    chk("mis_valid", ifu_rvalid, 1);
    chk("mis_inst", inst, 32'h0);
    chk("mis_fault", ifu_fault, 1);
    chk("mis_pc", pc, 32'h3000_0002);
    idu_ready = 1'b1; pc_update_valid = 1'b1; dnpc = 32'h3000_0020;
    tick;
    idu_ready = 1'b0; pc_update_valid = 1'b0;
    chk("same_edge_drop", ifu_rvalid, 0);
    tick;
    chk("same_edge_arvalid", arvalid, 1);
    chk("same_edge_araddr", araddr, 32'h3000_0020);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_ifu_rvalid", ifu_rvalid, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("re_arvalid", arvalid, 1);
    chk("re_araddr", araddr, 32'h3000_0000);
    chk("re_ifu_rvalid", ifu_rvalid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
